// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge control stage: turns qualified AHB transfers into APB
// SETUP/ACCESS sequences, with a write-data holding register for AHB phase skew.
module apb_fsm_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 3
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  valid,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic                  hwrite,
    input  logic [NUM_SLAVES-1:0] tempselx,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    output logic                  pwrite,
    output logic                  penable,
    output logic [NUM_SLAVES-1:0] pselx,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic                  hreadyout,
    output logic [DATA_WIDTH-1:0] hrdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WWAIT  = 2'd1;
    localparam logic [1:0] S_SETUP  = 2'd2;
    localparam logic [1:0] S_ACCESS = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [NUM_SLAVES-1:0] r_sel;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic w_ready;
    logic w_take;
    logic w_apb_active;

    // A new transfer is only taken while the AHB side sees hreadyout high.
    assign w_ready      = (r_state == S_IDLE) || (r_state == S_ACCESS);
    assign w_take       = w_ready && valid && (tempselx != '0);
    assign w_apb_active = (r_state == S_SETUP) || (r_state == S_ACCESS);

    always_ff @(posedge hclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (hreset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_sel   <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE:   if (w_take) r_state <= hwrite ? S_WWAIT : S_SETUP;
                S_WWAIT:  r_state <= S_SETUP;
                S_SETUP:  r_state <= S_ACCESS;
                S_ACCESS: r_state <= w_take ? (hwrite ? S_WWAIT : S_SETUP) : S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
            // Loading in ACCESS is safe: this cycle's APB outputs use the old values.
            if (w_take) begin
                r_addr  <= haddr;
                r_sel   <= tempselx;
                r_write <= hwrite;
            end
            if (r_state == S_WWAIT) r_wdata <= hwdata;
        end
    end

    assign hreadyout = w_ready;
    assign pselx     = w_apb_active ? r_sel   : '0;
    assign penable   = (r_state == S_ACCESS);
    assign pwrite    = w_apb_active ? r_write : 1'b0;
    assign paddr     = w_apb_active ? r_addr  : '0;
    assign pwdata    = w_apb_active ? r_wdata : '0;
    assign hrdata    = ((r_state == S_ACCESS) && !r_write) ? prdata : '0;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Self-checking bench for apb_fsm_controller: a transaction-schedule model
// predicts every output cycle, plus hand-computed literal checks per scenario.
module tb_apb_fsm_controller;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        valid;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  tempselx;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        pwrite;
    logic        penable;
    logic [2:0]  pselx;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        hreadyout;
    logic [31:0] hrdata;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    apb_fsm_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(3)) dut (
        .hclk(hclk), .hreset(hreset), .valid(valid), .haddr(haddr),
        .hwrite(hwrite), .tempselx(tempselx), .hwdata(hwdata), .prdata(prdata),
        .pwrite(pwrite), .penable(penable), .pselx(pselx), .paddr(paddr),
        .pwdata(pwdata), .hreadyout(hreadyout), .hrdata(hrdata)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: each accepted transfer becomes a list of future bus cycles.
    typedef enum logic [1:0] {K_WAIT, K_SETUP, K_ACCESS} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] addr;
        logic [2:0]  sel;
        logic        wr;
    } cyc_t;

    cyc_t        m_q[$];
    logic [31:0] m_wdata = '0;

    function automatic bit m_ready();
        return (m_q.size() == 0) || (m_q[0].kind == K_ACCESS);
    endfunction

    always @(posedge hclk) begin
        bit   rdy;
        cyc_t c;
        if (hreset) begin
            m_q.delete();
            m_wdata = '0;
        end else begin
            rdy = m_ready();
            if (m_q.size() > 0) begin
                if (m_q[0].kind == K_WAIT) m_wdata = hwdata;
                void'(m_q.pop_front());
            end
            if (rdy && valid && tempselx != 3'b000) begin
                c.addr = haddr; c.sel = tempselx; c.wr = hwrite;
                if (hwrite) begin c.kind = K_WAIT; m_q.push_back(c); end
                c.kind = K_SETUP;  m_q.push_back(c);
                c.kind = K_ACCESS; m_q.push_back(c);
            end
        end
    end

    function automatic logic [127:0] pack(logic rdy, logic [2:0] sel, logic en, logic wr,
                                          logic [31:0] a, logic [31:0] wd, logic [31:0] rd);
        return {26'b0, rdy, sel, en, wr, a, wd, rd};
    endfunction

    always @(negedge hclk) begin
        logic [127:0] exp;
        if (cmp_en) begin
            if (m_q.size() == 0)
                exp = pack(1'b1, 3'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
            else if (m_q[0].kind == K_WAIT)
                exp = pack(1'b0, 3'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
            else if (m_q[0].kind == K_SETUP)
                exp = pack(1'b0, m_q[0].sel, 1'b0, m_q[0].wr, m_q[0].addr, m_wdata, 32'h0);
            else
                exp = pack(1'b1, m_q[0].sel, 1'b1, m_q[0].wr, m_q[0].addr, m_wdata,
                           m_q[0].wr ? 32'h0 : prdata);
            check("cycle_model", pack(hreadyout, pselx, penable, pwrite, paddr, pwdata, hrdata), exp);
        end
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic w, input logic [2:0] s);
        valid = v; haddr = a; hwrite = w; tempselx = s;
    endtask

    initial begin
        hreset = 1'b1; hwdata = '0; prdata = '0;
        drive(1'b0, 32'h0, 1'b0, 3'b000);
        tick(); tick();
        check("reset_outputs", pack(hreadyout, pselx, penable, pwrite, paddr, pwdata, hrdata),
              pack(1'b1, 3'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0));
        hreset = 1'b0;
        cmp_en = 1'b1;
        tick();

        // Single read
        drive(1'b1, 32'h8000_0010, 1'b0, 3'b001); prdata = 32'd25;
        tick(); drive(1'b0, 32'h0, 1'b0, 3'b000);
        check("rd_setup_psel", {pselx, penable, hreadyout}, {3'b001, 1'b0, 1'b0});
        tick();
        check("rd_access", {penable, hreadyout, hrdata}, {1'b1, 1'b1, 32'd25});
        tick();
        check("rd_idle", {pselx, hreadyout}, {3'b000, 1'b1});

        // Single write
        drive(1'b1, 32'h8400_0020, 1'b1, 3'b010);
        tick(); drive(1'b0, 32'h0, 1'b0, 3'b000); hwdata = 32'hDEAD_BEEF;
        check("wr_wwait", {pselx, hreadyout}, {3'b000, 1'b0});
        tick(); hwdata = 32'h0;
        check("wr_setup", {paddr, pwdata, pwrite, pselx, penable},
              {32'h8400_0020, 32'hDEAD_BEEF, 1'b1, 3'b010, 1'b0});
        tick();
        check("wr_access", {penable, hreadyout, hrdata}, {1'b1, 1'b1, 32'h0});
        tick();

        // Back-to-back read -> write -> read
        drive(1'b1, 32'h8000_0000, 1'b0, 3'b001); prdata = 32'h0000_0077;
        tick(); drive(1'b0, 32'h0, 1'b0, 3'b000);
        tick();
        check("b2b_rd_access", {penable, hreadyout, hrdata}, {1'b1, 1'b1, 32'h77});
        drive(1'b1, 32'h8800_0004, 1'b1, 3'b100);
        tick(); drive(1'b0, 32'h0, 1'b0, 3'b000); hwdata = 32'h1234_5678;
        check("b2b_wwait_no_idle", {hreadyout, pselx}, {1'b0, 3'b000});
        tick();
        check("b2b_wr_setup", {pselx, pwrite, paddr, pwdata}, {3'b100, 1'b1, 32'h8800_0004, 32'h1234_5678});
        tick();
        check("b2b_wr_access", {penable, hreadyout}, {1'b1, 1'b1});
        drive(1'b1, 32'h8000_0008, 1'b0, 3'b001);
        tick(); drive(1'b0, 32'h0, 1'b0, 3'b000);
        check("b2b_rd_setup", {pselx, penable, hreadyout, paddr}, {3'b001, 1'b0, 1'b0, 32'h8000_0008});
        tick(); tick();

        // Null select ignored
        drive(1'b1, 32'h8000_0100, 1'b0, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("null_sel", {pselx, hreadyout, penable}, {3'b000, 1'b1, 1'b0});
        end
        drive(1'b0, 32'h0, 1'b0, 3'b000);

        // Reset in SETUP of a write
        drive(1'b1, 32'h8400_0040, 1'b1, 3'b010);
        tick(); drive(1'b0, 32'h0, 1'b0, 3'b000); hwdata = 32'hCAFE_F00D;
        tick();
        check("rst_pre_setup", {pselx, penable}, {3'b010, 1'b0});
        hreset = 1'b1;
        tick(); hreset = 1'b0;
        check("rst_mid_write", pack(hreadyout, pselx, penable, pwrite, paddr, pwdata, hrdata),
              pack(1'b1, 3'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0));
        tick();
        check("rst_no_access", {penable, pselx}, {1'b0, 3'b000});

        // Reset overrides a simultaneous accept
        hreset = 1'b1; drive(1'b1, 32'h8000_0200, 1'b0, 3'b001);
        tick(); hreset = 1'b0; drive(1'b0, 32'h0, 1'b0, 3'b000);
        check("rst_over_accept", {pselx, hreadyout}, {3'b000, 1'b1});
        tick();

        // Random legal traffic; the per-cycle model compare does the checking.
        for (int i = 0; i < 300; i++) begin
            hwdata = $urandom();
            prdata = $urandom();
            if (m_ready() && ($urandom_range(0, 3) != 0))
                drive(1'b1, $urandom(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            else
                drive(1'b0, $urandom(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 3'b000);
        tick(); tick(); tick(); tick();
        check("drain_idle", {pselx, penable, hreadyout}, {3'b000, 1'b0, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_fsm_controller.md
# apb_fsm_controller

Bridge control stage between the AHB slave interface and the APB interface stage: converts qualified AHB transfers into APB SETUP/ACCESS sequences. Drives pwrite/penable/pselx/paddr/pwdata into the APB interface stage and returns read data and hreadyout to the AHB side. APB slaves have no pready, so every ACCESS phase is exactly one cycle. One write-data holding register covers the AHB address/data phase skew.

## Interface

- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- NUM_SLAVES, 3, width of pselx / tempselx (one bit per APB slave)

- hclk  in  1  clock; all state changes on rising edge
- hreset  in  1  synchronous, active-high reset
- valid  in  1  AHB address phase qualified (hsel, NONSEQ/SEQ, hready high)
- haddr  in  ADDR_WIDTH  AHB address, sampled with valid
- hwrite  in  1  AHB direction, sampled with valid
- tempselx  in  NUM_SLAVES  decoded slave select, sampled with valid
- hwdata  in  DATA_WIDTH  AHB write data, sampled in WWAIT
- prdata  in  DATA_WIDTH  read data from APB interface stage
- pwrite  out  1  APB direction
- penable  out  1  APB enable
- pselx  out  NUM_SLAVES  APB slave select
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- hreadyout  out  1  transfer-complete / ready to AHB
- hrdata  out  DATA_WIDTH  read data to AHB

## Operation

- Accept = valid && (tempselx != 0). valid with tempselx == 0 is ignored (no APB activity).
- Holding regs addr_q, sel_q, write_q load on accept; wdata_q loads hwdata in WWAIT.
- States:
  - IDLE: hreadyout=1, pselx=0, penable=0. Accept & !hwrite -> SETUP. Accept & hwrite -> WWAIT. Else stay.
  - WWAIT: hreadyout=0, APB idle; wdata_q <= hwdata; -> SETUP.
  - SETUP: pselx=sel_q, penable=0, hreadyout=0; -> ACCESS unconditionally.
  - ACCESS: pselx=sel_q, penable=1, hreadyout=1; accept here = back-to-back: read -> SETUP, write -> WWAIT; no accept -> IDLE.
- pwrite=write_q, paddr=addr_q, pwdata=wdata_q whenever pselx != 0; all three 0 in IDLE/WWAIT.
- hrdata = prdata in ACCESS when write_q=0; 0 otherwise.
- valid ignored in WWAIT and SETUP (hreadyout low; master must not present new address).
- tempselx latched as given; one-hot not checked.
- APB outputs and hreadyout decode from state and holding regs only; no combinational path from AHB inputs. Only hrdata is combinational (from prdata).

## Timing

- Reset (hreset high at edge): state IDLE, holding regs 0; outputs hreadyout=1, pselx=0, penable=0, pwrite=0, paddr=0, pwdata=0, hrdata=0. hreset overrides accept in the same cycle.
- Reset mid-transfer: next edge IDLE, pselx/penable drop to 0, transfer abandoned, no completion signalled.
- Read: accept at cycle N; SETUP N+1; ACCESS N+2 with hreadyout=1, hrdata valid. One AHB wait state.
- Write: accept at N; WWAIT N+1 (hwdata captured); SETUP N+2; ACCESS N+3, hreadyout=1. Two wait states.
- Back-to-back: accept in ACCESS at M gives SETUP (read) or WWAIT (write) at M+1; no IDLE gap; pselx stays asserted across read->read.
- penable never high without pselx; penable high exactly one cycle per transfer; paddr/pwrite/pwdata stable SETUP through ACCESS.

## Test plan

- Single read: accept haddr=0x8000_0010, hwrite=0, tempselx=3'b001; prdata returns 25 when penable&!pwrite -> N+1 pselx=001 penable=0 hreadyout=0; N+2 penable=1, hreadyout=1, hrdata=25; N+3 IDLE, pselx=0.
- Single write: accept haddr=0x8400_0020, tempselx=3'b010; hwdata=0xDEAD_BEEF at N+1 -> N+2 SETUP paddr=0x8400_0020 pwdata=0xDEAD_BEEF pwrite=1; N+3 penable=1 hreadyout=1.
- Back-to-back: read to 0x8000_0000 then accept write to 0x8800_0004 (sel 100) in its ACCESS -> WWAIT next cycle, SETUP with pselx=100, no IDLE cycle; then accept read in write ACCESS -> SETUP next cycle.
- Null select: valid=1, tempselx=000 in IDLE for 3 cycles -> state IDLE, pselx=0, hreadyout=1 throughout.
- Reset mid-write: assert hreset in SETUP of a write -> next cycle IDLE, all outputs at reset values, penable never asserted for that transfer.
- Invariants over random legal traffic: penable implies pselx!=0; hreadyout low only in WWAIT/SETUP; hrdata=0 outside read ACCESS.
